// File: rtl/imem_loadable.sv
// Loadable instruction memory: synchronous-read word array with a streaming program-load FSM.
// Latency: fetch data, pc and fault appear 1 cycle after an accepted request; loads write 1 word per valid edge.
// Backpressure: stall freezes all fetch outputs; load_ready is high only in LOAD, so fetches are serviced only in IDLE.
module imem_loadable #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 256,
    parameter int              ADDR_MODE   = 0,
    parameter logic [XLEN-1:0] FAULT_INSTR = '0,
    localparam int             AW          = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            fetch_req,
    input  logic [31:0]     pc,
    input  logic            stall,
    output logic [XLEN-1:0] instruction,
    output logic [31:0]     instr_pc,
    output logic            instr_valid,
    output logic            fault,

    input  logic            load_start,
    input  logic [AW-1:0]   load_base,
    input  logic [AW:0]     load_len,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    output logic            load_ready,
    output logic            load_done,
    output logic            load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [32:0] DEPTH_W = 33'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [XLEN-1:0] mem [DEPTH];

    state_t        state;
    logic [AW:0]   ptr;
    logic [AW:0]   cnt;

    logic [31:0]   fetch_word;
    logic          fetch_fault;
    logic [AW-1:0] fetch_idx;
    logic          wr_en;
    logic          wr_drop;

    // Range check runs on the full 32-bit word index so large pcs never alias onto low entries.
    always_comb begin
        fetch_word  = (ADDR_MODE == 1) ? {2'b00, pc[31:2]} : pc;
        fetch_fault = ({1'b0, fetch_word} >= DEPTH_W);
        if (ADDR_MODE == 1 && pc[1:0] != 2'b00) begin
            fetch_fault = 1'b1;
        end
        fetch_idx = fetch_word[AW-1:0];
    end

    // ptr is one bit wider than the array index; its top bit marks writes past the last word.
    assign wr_en   = !rst && state == LOAD && load_valid && !ptr[AW];
    assign wr_drop = state == LOAD && load_valid && ptr[AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            instruction <= FAULT_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            load_done <= 1'b0;

            // Fetch path; stall overrides everything, including the state-based gating.
            if (!stall) begin
                if (state == IDLE && fetch_req) begin
                    instr_valid <= 1'b1;
                    instr_pc    <= pc;
                    fault       <= fetch_fault;
                    instruction <= fetch_fault ? FAULT_INSTR : mem[fetch_idx];
                end else begin
                    instr_valid <= 1'b0;
                    fault       <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (load_start) begin
                        ptr      <= {1'b0, load_base};
                        cnt      <= load_len;
                        load_err <= 1'b0;
                        if (load_len == '0) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            load_ready <= 1'b0;
                        end else begin
                            state      <= LOAD;
                            load_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr <= ptr + ONE;
                        cnt <= cnt - ONE;
                        if (wr_drop) begin
                            load_err <= 1'b1;
                        end
                        if (cnt == ONE) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory for the h2bp core; successor to the fixed 8-entry hard-coded instruction ROM.
- Synchronous-read array of DEPTH words, XLEN wide, with a 1-cycle fetch port and fetch stall/hold.
- Selectable word or byte PC addressing; out-of-range and misaligned PCs are flagged as faults.
- Streaming program-load port driven by a small FSM, so programs are written at run time instead of coded as case entries.

Parameters:
XLEN, 32, instruction/data word width.
DEPTH, 256, number of words (power of two, >=2); AW = clog2(DEPTH) derived internally.
ADDR_MODE, 0, 0 = pc is a word index; 1 = pc is a byte address (index = pc>>2).
FAULT_INSTR, 0, word returned on a faulting fetch (XLEN wide).

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch request this cycle
pc  in  32  fetch address
stall  in  1  hold all fetch outputs
instruction  out  XLEN  fetched word
instr_pc  out  32  pc that produced instruction
instr_valid  out  1  instruction/instr_pc/fault valid
fault  out  1  fetch was out of range or misaligned
load_start  in  1  begin load sequence (IDLE only)
load_base  in  AW  first word index to write
load_len  in  AW+1  number of words to write
load_valid  in  1  load_data valid
load_data  in  XLEN  word to write
load_ready  out  1  loader accepts load_data
load_done  out  1  1-cycle pulse, load finished
load_err  out  1  sticky, a write was dropped past DEPTH-1

Behaviour:
- Reset values:
  - instruction = FAULT_INSTR; instr_pc = 0.
  - instr_valid, fault, load_ready, load_done, load_err = 0.
  - FSM state = IDLE.
  - Array contents are not cleared.
- Reset mid-load: FSM returns to IDLE. Words already written remain.
- Index and fault rules:
  - ADDR_MODE=0: idx = pc; fault if pc >= DEPTH.
  - ADDR_MODE=1: idx = pc[31:2]; fault if pc[1:0] != 0 or idx >= DEPTH.
  - Range compare uses the full 32-bit pc (no truncation or wrap).
- Fetch, accepted only in IDLE:
  - Edge with fetch_req=1, stall=0: next cycle instr_valid=1, instr_pc=pc, instruction=mem[idx] (or FAULT_INSTR with fault=1 if faulting). Latency is exactly 1 cycle.
  - Edge with stall=1: instruction, instr_pc, instr_valid, fault all hold; pc/fetch_req ignored. Stall has priority over everything in the fetch path.
  - Edge with fetch_req=0, stall=0: instr_valid=0, fault=0; instruction and instr_pc hold.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start: ptr = load_base, cnt = load_len, load_err cleared.
  - If load_len = 0, IDLE -> DONE directly.
  - Simultaneous load_start and fetch_req in IDLE: the fetch is serviced this cycle; the load starts the same edge.
- LOAD state:
  - load_ready = 1.
  - Each edge with load_valid=1: write load_data to mem[ptr] if ptr < DEPTH, else drop the word and set load_err. Then ptr++ (ptr is AW+1 bits wide, so no wrap) and cnt--.
  - When cnt goes 1 -> 0, move to DONE.
  - load_start is ignored.
  - Fetches are not serviced: instr_valid=0 unless stall holds a prior valid.
- DONE state:
  - load_done = 1 for exactly one cycle, load_ready = 0.
  - Next state IDLE.
  - The first fetch can be issued in the cycle after DONE and sees the new data.
- Write and read never coincide in the same cycle, so there is no read-during-write hazard.

Test Plan:
- Reset, then load base=0 len=4 data A0..A3 with continuous load_valid -> load_ready high 4 cycles, load_done pulses 1 cycle after the 4th write, load_err=0.
- ADDR_MODE=0, fetch pc=0,1,2,3 back-to-back -> next cycles instruction=A0..A3, instr_pc=0..3, instr_valid=1, fault=0.
- Fetch pc=2 with stall high 3 cycles starting the cycle after issue -> instruction=A2 and instr_valid=1 held 3 cycles; pc changed to 5 during the stall is ignored.
- DEPTH=256, fetch pc=256 -> instr_valid=1, fault=1, instruction=FAULT_INSTR. With ADDR_MODE=1, pc=6 -> fault=1; pc=8 -> instruction=mem[2].
- Load base=254 len=4, then fetch 254/255 -> words 0-1 written to 254/255, words 2-3 dropped, load_err=1 stays set until the next load_start; fetches return the loaded words.
- Load of len=8 with rst asserted after 3 writes; fetch_req held during LOAD -> instr_valid=0 throughout LOAD. After reset, state IDLE, load_ready=0, and fetches of the first 3 indices return the new words.
